// File: rtl/alarm_pkg.sv
// Shared types and constants for the keypad alarm controller: FSM state
// encoding, the no-key code and the key-entry timeout length.
package alarm_pkg;

    typedef enum logic [2:0] {
        SHOW_TIME        = 3'd0,
        KEY_STORED       = 3'd1,
        KEY_WAITED       = 3'd2,
        KEY_ENTRY        = 3'd3,
        SHOW_ALARM       = 3'd4,
        SET_ALARM_TIME   = 3'd5,
        SET_CURRENT_TIME = 3'd6
    } state_e;

    localparam logic [3:0] NOKEY        = 4'd10;
    localparam int         TIMEOUT_SECS = 10;
    // The event fires on the pulse that would take the count past this value.
    localparam logic [3:0] CNT_MAX      = 4'(TIMEOUT_SECS - 1);

    function automatic logic is_digit(input logic [3:0] k);
        return (k < NOKEY);
    endfunction

endpackage

// File: rtl/keypad_alarm_ctrl_if.sv
// Bundle of the keypad/button inputs and display/load controls of the
// alarm controller, with stimulus-side (master) and controller-side (slave) views.
interface keypad_alarm_ctrl_if;
    logic       one_second;
    logic [3:0] key;
    logic       alarm_button;
    logic       time_button;
    logic       load_new_alarm;
    logic       load_new_time;
    logic       show_new_time;
    logic       show_a;
    logic       shift;

    modport master (
        output one_second, key, alarm_button, time_button,
        input  load_new_alarm, load_new_time, show_new_time, show_a, shift
    );

    modport slave (
        input  one_second, key, alarm_button, time_button,
        output load_new_alarm, load_new_time, show_new_time, show_a, shift
    );
endinterface

// File: rtl/key_timeout_cnt.sv
// Saturating seconds counter for the key-entry states; flags the timeout on
// the pulse that arrives while the count already sits at its maximum.
module key_timeout_cnt
    import alarm_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic one_second,
    input  logic enable,
    input  logic clear,
    output logic time_out
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    // Clear has priority over counting so a pulse on a state change is dropped.
    always_comb begin
        count_d = count_q;
        if (clear || !enable) begin
            count_d = 4'd0;
        end else if (one_second && (count_q < CNT_MAX)) begin
            count_d = count_q + 4'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign time_out = enable && one_second && (count_q == CNT_MAX);

endmodule

// File: rtl/keypad_alarm_ctrl.sv
// Moore FSM sequencing keypad entry, alarm display and the alarm/time load
// strobes; all outputs come from flops tracking the state register.
module keypad_alarm_ctrl
    import alarm_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       one_second,
    input  logic [3:0] key,
    input  logic       alarm_button,
    input  logic       time_button,
    output logic       load_new_alarm,
    output logic       load_new_time,
    output logic       show_new_time,
    output logic       show_a,
    output logic       shift
);

    state_e     state_q;
    state_e     state_d;
    logic [4:0] out_q;
    logic [4:0] out_d;
    logic       in_entry_s;
    logic       time_out_s;

    assign in_entry_s = (state_q == KEY_WAITED) || (state_q == KEY_ENTRY);

    key_timeout_cnt u_timeout (
        .clock      (clock),
        .reset      (reset),
        .one_second (one_second),
        .enable     (in_entry_s),
        .clear      (state_d != state_q),
        .time_out   (time_out_s)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SHOW_TIME: begin
                if (alarm_button)       state_d = SHOW_ALARM;
                else if (is_digit(key)) state_d = KEY_STORED;
                else                    state_d = SHOW_TIME;
            end
            KEY_STORED:       state_d = KEY_WAITED;
            KEY_WAITED: begin
                if (!is_digit(key))     state_d = KEY_ENTRY;
                else if (time_out_s)    state_d = SHOW_TIME;
                else                    state_d = KEY_WAITED;
            end
            KEY_ENTRY: begin
                if (alarm_button)       state_d = SET_ALARM_TIME;
                else if (time_button)   state_d = SET_CURRENT_TIME;
                else if (time_out_s)    state_d = SHOW_TIME;
                else if (is_digit(key)) state_d = KEY_STORED;
                else                    state_d = KEY_ENTRY;
            end
            SHOW_ALARM: begin
                if (!alarm_button)      state_d = SHOW_TIME;
                else                    state_d = SHOW_ALARM;
            end
            SET_ALARM_TIME:   state_d = SHOW_TIME;
            SET_CURRENT_TIME: state_d = SHOW_TIME;
            default:          state_d = SHOW_TIME;
        endcase
    end

    // Output decode of the upcoming state, packed as
    // {load_new_alarm, load_new_time, show_new_time, show_a, shift}.
    always_comb begin
        out_d = 5'b00000;
        case (state_d)
            KEY_STORED:       out_d = 5'b00101;
            KEY_WAITED:       out_d = 5'b00100;
            KEY_ENTRY:        out_d = 5'b00100;
            SHOW_ALARM:       out_d = 5'b00010;
            SET_ALARM_TIME:   out_d = 5'b10000;
            SET_CURRENT_TIME: out_d = 5'b01000;
            default:          out_d = 5'b00000;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= SHOW_TIME;
            out_q   <= 5'b00000;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign load_new_alarm = out_q[4];
    assign load_new_time  = out_q[3];
    assign show_new_time  = out_q[2];
    assign show_a         = out_q[1];
    assign shift          = out_q[0];

endmodule
